// File: rtl/cbuf_window_ctrl_pkg.sv
// Shared definitions for the circular line-buffer window controller:
// FSM state encoding and the address/count width helpers.
package cbuf_window_ctrl_pkg;

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  // Address width for a buffer of depth entries (entries 0 .. depth-1).
  function automatic int aw_of(input int depth);
    return $clog2(depth);
  endfunction

  // Count width able to hold occupancy 0 .. depth inclusive.
  function automatic int cw_of(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cbuf_window_ctrl_mod_ptr.sv
// Wrapping pointer for a non-power-of-two ring: advances by STEP modulo
// DEPTH on inc, returns to zero on clr (clr wins over inc).
module mod_ptr
  import cbuf_window_ctrl_pkg::*;
#(
  parameter int DEPTH = 9,
  parameter int STEP  = 1,
  localparam int AW   = aw_of(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  // ptr < DEPTH and STEP <= DEPTH, so the sum stays below 2*DEPTH and one
  // extra bit is enough; a single conditional subtract performs the wrap.
  logic [AW:0]   sum;
  logic [AW-1:0] nxt;

  assign sum = {1'b0, ptr} + (AW+1)'(STEP);
  assign nxt = (sum >= (AW+1)'(DEPTH)) ? AW'(sum - (AW+1)'(DEPTH)) : sum[AW-1:0];

  // Pointer register: clear has priority over advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= nxt;
    end
  end

endmodule

// File: rtl/cbuf_window_ctrl.sv
// Circular line-buffer controller: owns write/read base pointers and the
// occupancy count, gates producer writes and consumer reads, and sequences
// each frame through FILL (priming), STREAM and DRAIN (end-of-frame flush-out).
module cbuf_window_ctrl
  import cbuf_window_ctrl_pkg::*;
#(
  parameter int DEPTH = 9,
  parameter int WPAR  = 2,
  parameter int RPAR  = 3,
  parameter int PRIME = 6,
  localparam int AW   = aw_of(DEPTH),
  localparam int CW   = cw_of(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_req,
  input  logic          wr_last,
  output logic          wr_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW-1:0] rd_addr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          done
);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          rd_en;
  logic          drain_end;
  logic          ptr_clr;

  // Handshakes look only at registered count/state: no same-cycle pass-through.
  assign wr_ready  = (count <= CW'(DEPTH - WPAR)) && (state != ST_DRAIN);
  assign rd_valid  = (state != ST_FILL) && (count >= CW'(RPAR));
  assign wr_en     = wr_req && wr_ready;
  assign rd_en     = rd_valid && rd_ready;
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

  // In DRAIN, fewer than RPAR words can never form a window; they are dropped.
  assign drain_end = (state == ST_DRAIN) && (count < CW'(RPAR));
  assign ptr_clr   = flush || drain_end;

  mod_ptr #(.DEPTH(DEPTH), .STEP(WPAR)) u_wptr (
    .clk (clk),
    .rst (rst),
    .clr (ptr_clr),
    .inc (wr_en),
    .ptr (wr_addr)
  );

  mod_ptr #(.DEPTH(DEPTH), .STEP(RPAR)) u_rptr (
    .clk (clk),
    .rst (rst),
    .clr (ptr_clr),
    .inc (rd_en),
    .ptr (rd_addr)
  );

  // Next occupancy: a concurrent write and read net to WPAR-RPAR in one cycle.
  always_comb begin
    cnt_nxt = count;
    if (wr_en) cnt_nxt = cnt_nxt + CW'(WPAR);
    if (rd_en) cnt_nxt = cnt_nxt - CW'(RPAR);
  end

  // Occupancy register; flush and drain completion both empty the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (ptr_clr) begin
      count <= '0;
    end else begin
      count <= cnt_nxt;
    end
  end

  // Frame sequencing; an end-of-frame write beats the priming transition.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL: begin
        if (wr_en && wr_last)          state_nxt = ST_DRAIN;
        else if (count >= CW'(PRIME))  state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (wr_en && wr_last)          state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_end)                 state_nxt = ST_FILL;
      end
      default:                         state_nxt = ST_FILL;
    endcase
    if (flush) state_nxt = ST_FILL;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // One-cycle completion pulse; a flush in the same cycle suppresses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= drain_end && !flush;
    end
  end

endmodule
